// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 DCT coefficient accumulator.
// Holds the block geometry, Q.8 rounding constants, the FSM state type and the LUT index type.
package dct_pkg;

    localparam int BLK_N         = 8;
    localparam int BLK_PIXELS    = 64;
    localparam int COS_FRAC_BITS = 8;
    localparam int ROUND_BIAS    = 128;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } dct_acc_state_t;

    typedef logic [2:0] dct_idx_t;

endpackage

// File: rtl/dct_round_shift.sv
// Rounds a Q.8 accumulator to an integer coefficient: (acc + 0.5) >>> 8, truncated to COEF_W.
// Latency: combinational. Backpressure: none.
module dct_round_shift
    import dct_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int COEF_W = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [COEF_W-1:0] coef_o
);

    // The arithmetic shift floors, so adding half an LSB first gives round-half-up.
    assign coef_o = COEF_W'(($signed(acc_i) + ACC_W'(ROUND_BIAS)) >>> COS_FRAC_BITS);

endmodule

// File: rtl/dct_coeff_accum.sv
// Streaming 8x8 DCT MAC: one pixel per cycle times the LUT cosine term, one rounded coefficient per block.
// Latency: coef_valid one cycle after the 64th pixel handshake. Backpressure: pix_ready drops while a coefficient waits for coef_ready.
// Build option: DCT_LEVEL_SHIFT_EN subtracts 128 from each pixel before the multiply.
module dct_coeff_accum
    import dct_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 32,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [2:0]        n1,
    output logic [2:0]        n2,
    input  logic [31:0]       cos_term,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data
);

    dct_acc_state_t     state_q, state_d;
    dct_idx_t           n1_q, n1_d;
    dct_idx_t           n2_q, n2_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               pix_ready_q, pix_ready_d;
    logic               coef_valid_q, coef_valid_d;
    logic [COEF_W-1:0]  coef_data_q, coef_data_d;

    logic signed [PIX_W:0]   samp;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] cos_ext;
    logic [ACC_W-1:0]        acc_sum;
    logic [COEF_W-1:0]       coef_rnd;
    logic                    pix_fire;
    logic                    last_pix;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam logic [PIX_W:0] LVL_OFS = (PIX_W+1)'(1) << (PIX_W - 1);
    assign samp = $signed({1'b0, pix_data} - LVL_OFS);
`else
    assign samp = $signed({1'b0, pix_data});
`endif

    assign samp_ext = ACC_W'(samp);
    assign cos_ext  = ACC_W'($signed(cos_term));
    assign acc_sum  = ACC_W'($signed(acc_q) + samp_ext * cos_ext);

    // The final coefficient rounds the sum including the 64th product, so it is taken from acc_sum.
    dct_round_shift #(
        .ACC_W  (ACC_W),
        .COEF_W (COEF_W)
    ) u_round (
        .acc_i  (acc_sum),
        .coef_o (coef_rnd)
    );

    assign pix_fire = pix_valid && pix_ready_q && (state_q == ACCUM) && !clr;
    assign last_pix = (n1_q == dct_idx_t'(BLK_N - 1)) && (n2_q == dct_idx_t'(BLK_N - 1));

    always_comb begin
        state_d      = state_q;
        n1_d         = n1_q;
        n2_d         = n2_q;
        acc_d        = acc_q;
        coef_valid_d = coef_valid_q;
        coef_data_d  = coef_data_q;

        if (clr) begin
            state_d      = ACCUM;
            n1_d         = '0;
            n2_d         = '0;
            acc_d        = '0;
            coef_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (pix_fire) begin
                        acc_d        = acc_sum;
                        {n1_d, n2_d} = {n1_q, n2_q} + 6'd1;
                        if (last_pix) begin
                            coef_valid_d = 1'b1;
                            coef_data_d  = coef_rnd;
                            state_d      = EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (coef_ready) begin
                        coef_valid_d = 1'b0;
                        acc_d        = '0;
                        state_d      = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end

        pix_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            n1_q         <= '0;
            n2_q         <= '0;
            acc_q        <= '0;
            pix_ready_q  <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            n1_q         <= n1_d;
            n2_q         <= n2_d;
            acc_q        <= acc_d;
            pix_ready_q  <= pix_ready_d;
            coef_valid_q <= coef_valid_d;
            coef_data_q  <= coef_data_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign n1         = n1_q;
    assign n2         = n2_q;
    assign coef_valid = coef_valid_q;
    assign coef_data  = coef_data_q;

endmodule
